// File: rtl/zigzag_pkg.sv
// -----------------------------------------------------------------------------
// zigzag_pkg
// Shared constants and types for the zigzag reorder buffer controller.
//   BLK_SIZE   : coefficients per 8x8 block
//   IDX_W      : width of an index inside one block
//   RAM_ADDR_W : RAMZ address width ({bank, index})
//   bank_state_e : occupancy state of one RAMZ bank
//   ZZ_TABLE   : JPEG zigzag scan index -> row-major address
// -----------------------------------------------------------------------------
package zigzag_pkg;

   localparam int BLK_SIZE   = 64;
   localparam int IDX_W      = 6;
   localparam int RAM_ADDR_W = 7;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_e;

   localparam logic [IDX_W-1:0] ZZ_TABLE [BLK_SIZE] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage : zigzag_pkg

// File: rtl/zigzag_lut.sv
// -----------------------------------------------------------------------------
// zigzag_lut
// Combinational map from zigzag scan index to row-major block address.
// Ports:
//   scan_idx    in  6  position in the zigzag scan
//   raster_addr out 6  row-major address of that coefficient
// -----------------------------------------------------------------------------
module zigzag_lut
   import zigzag_pkg::*;
(
   input  logic [IDX_W-1:0] scan_idx,
   output logic [IDX_W-1:0] raster_addr
);

   // Table lookup
   always_comb begin
      raster_addr = ZZ_TABLE[scan_idx];
   end

endmodule : zigzag_lut

// File: rtl/zigzag_buf_ctrl.sv
// -----------------------------------------------------------------------------
// zigzag_buf_ctrl
// Ping-pong buffer controller between the 2-D DCT and the quantizer. Blocks
// arrive row-major, are written into an external two-bank RAMZ, and are read
// back in zigzag order through a 2-entry skid FIFO with valid/ready output.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/valid/ready row-major coefficient input stream
//   ram_d/waddr/we      RAMZ write port ({bank, row-major index})
//   ram_raddr/rd/q      RAMZ read port ({bank, zigzag index}), q one cycle late
//   out_data/valid/ready/last  zigzag-ordered output stream
// Optional (macro ZIGZAG_BUF_DBG_CNT_EN):
//   dbg_blk_in, dbg_blk_out  wrapping block counters
//   dbg_stall_err            sticky input-stall watchdog (>256 cycles)
// -----------------------------------------------------------------------------
module zigzag_buf_ctrl
   import zigzag_pkg::*;
#(
   parameter int DATA_W = 12
`ifdef ZIGZAG_BUF_DBG_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_W-1:0]     ram_d,
   output logic [RAM_ADDR_W-1:0] ram_waddr,
   output logic                  ram_we,
   output logic [RAM_ADDR_W-1:0] ram_raddr,
   output logic                  ram_rd,
   input  logic [DATA_W-1:0]     ram_q,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
`ifdef ZIGZAG_BUF_DBG_CNT_EN
   , output logic [CNT_W-1:0]    dbg_blk_in
   , output logic [CNT_W-1:0]    dbg_blk_out
   , output logic                dbg_stall_err
`endif
);

   bank_state_e      bank_r [2];
   logic             wr_bank_r;
   logic             rd_bank_r;
   logic [IDX_W-1:0] wr_idx_r;
   // One extra bit: rd_idx_r==64 means "all reads issued, waiting for the
   // last capture before releasing the bank".
   logic [IDX_W:0]   rd_idx_r;
   logic             in_flight_r;
   logic             in_flight_last_r;

   logic [DATA_W-1:0] skid_data_r [2];
   logic [1:0]        skid_last_r;
   logic              skid_wr_ptr_r;
   logic              skid_rd_ptr_r;
   logic [1:0]        skid_cnt_r;

   logic             in_ready_s;
   logic             accept_s;
   logic             fill_s;
   logic             pop_s;
   logic             issue_s;
   logic             release_s;
   logic [2:0]       occ_s;
   logic [IDX_W-1:0] zz_addr_s;

   zigzag_lut u_lut (
      .scan_idx    (rd_idx_r[IDX_W-1:0]),
      .raster_addr (zz_addr_s)
   );

   // Handshake and issue decisions for this cycle
   always_comb begin
      in_ready_s = 1'b0;
      accept_s   = 1'b0;
      fill_s     = 1'b0;
      pop_s      = 1'b0;
      issue_s    = 1'b0;
      release_s  = 1'b0;
      occ_s      = 3'd0;

      if (bank_r[wr_bank_r] == BANK_EMPTY) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = 1'b0;
      end

      // Writes are suppressed while reset is asserted.
      accept_s = in_valid & in_ready_s & rst_n;
      fill_s   = accept_s & (wr_idx_r == 6'd63);

      pop_s = (skid_cnt_r != 2'd0) & out_ready;

      // Slots committed after this cycle's pop; a read is only issued when
      // its data is guaranteed a skid slot. Counting the pop keeps the read
      // side at one coefficient per cycle while the consumer is ready.
      occ_s = {1'b0, skid_cnt_r} + {2'b00, in_flight_r} - {2'b00, pop_s};

      if ((bank_r[rd_bank_r] == BANK_FULL) && !rd_idx_r[IDX_W] &&
          (occ_s < 3'd2) && rst_n) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end

      // The bank is freed only once its final coefficient has been captured.
      release_s = in_flight_r & in_flight_last_r;
   end

   // RAM port and stream outputs
   always_comb begin
      in_ready  = in_ready_s;
      ram_we    = accept_s;
      ram_waddr = {wr_bank_r, wr_idx_r};
      ram_rd    = issue_s;
      out_valid = (skid_cnt_r != 2'd0);
      out_data  = skid_data_r[skid_rd_ptr_r];
      out_last  = skid_last_r[skid_rd_ptr_r] & (skid_cnt_r != 2'd0);
      if (accept_s) begin
         ram_d = in_data;
      end else begin
         ram_d = {DATA_W{1'b0}};
      end
      if (issue_s) begin
         ram_raddr = {rd_bank_r, zz_addr_s};
      end else begin
         ram_raddr = {RAM_ADDR_W{1'b0}};
      end
   end

   // Write pointer, read pointer and bank occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_r[0]        <= BANK_EMPTY;
         bank_r[1]        <= BANK_EMPTY;
         wr_bank_r        <= 1'b0;
         rd_bank_r        <= 1'b0;
         wr_idx_r         <= 6'd0;
         rd_idx_r         <= 7'd0;
         in_flight_r      <= 1'b0;
         in_flight_last_r <= 1'b0;
      end else begin
         // Fill and release always target different banks.
         for (int b = 0; b < 2; b++) begin
            if (fill_s && (wr_bank_r == 1'(b))) begin
               bank_r[b] <= BANK_FULL;
            end else if (release_s && (rd_bank_r == 1'(b))) begin
               bank_r[b] <= BANK_EMPTY;
            end else begin
               bank_r[b] <= bank_r[b];
            end
         end

         if (accept_s) begin
            wr_idx_r <= wr_idx_r + 6'd1;
            if (fill_s) begin
               wr_bank_r <= ~wr_bank_r;
            end
         end

         if (release_s) begin
            rd_idx_r  <= 7'd0;
            rd_bank_r <= ~rd_bank_r;
         end else if (issue_s) begin
            rd_idx_r <= rd_idx_r + 7'd1;
         end

         in_flight_r      <= issue_s;
         in_flight_last_r <= issue_s & (rd_idx_r == 7'd63);
      end
   end

   // Skid FIFO: capture returning read data, pop on output handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         skid_data_r[0] <= {DATA_W{1'b0}};
         skid_data_r[1] <= {DATA_W{1'b0}};
         skid_last_r    <= 2'b00;
         skid_wr_ptr_r  <= 1'b0;
         skid_rd_ptr_r  <= 1'b0;
         skid_cnt_r     <= 2'd0;
      end else begin
         if (in_flight_r) begin
            skid_data_r[skid_wr_ptr_r] <= ram_q;
            skid_last_r[skid_wr_ptr_r] <= in_flight_last_r;
            skid_wr_ptr_r              <= ~skid_wr_ptr_r;
         end
         if (pop_s) begin
            skid_rd_ptr_r <= ~skid_rd_ptr_r;
         end
         skid_cnt_r <= skid_cnt_r + {1'b0, in_flight_r} - {1'b0, pop_s};
      end
   end

`ifdef ZIGZAG_BUF_DBG_CNT_EN
   logic [8:0] stall_run_r;

   // Debug block counters and input-stall watchdog
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dbg_blk_in    <= {CNT_W{1'b0}};
         dbg_blk_out   <= {CNT_W{1'b0}};
         dbg_stall_err <= 1'b0;
         stall_run_r   <= 9'd0;
      end else begin
         if (fill_s) begin
            dbg_blk_in <= dbg_blk_in + CNT_W'(1);
         end
         if (pop_s && skid_last_r[skid_rd_ptr_r]) begin
            dbg_blk_out <= dbg_blk_out + CNT_W'(1);
         end
         // stall_run_r counts prior consecutive stalled cycles; the 257th
         // stalled cycle sets the sticky flag.
         if (in_valid && !in_ready_s) begin
            if (stall_run_r == 9'd256) begin
               dbg_stall_err <= 1'b1;
            end else begin
               stall_run_r <= stall_run_r + 9'd1;
            end
         end else begin
            stall_run_r <= 9'd0;
         end
      end
   end
`endif

endmodule : zigzag_buf_ctrl

// File: tb/tb_zigzag_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zigzag_buf_ctrl
// Self-checking bench: RAMZ behavioural model, zigzag reference model built
// from the diagonal-scan rule, randomized stimulus and output scoreboard.
// -----------------------------------------------------------------------------
module tb_zigzag_buf_ctrl;

   localparam int DATA_W = 12;
   localparam int LIM    = 5000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] ram_d;
   logic [6:0]        ram_waddr;
   logic              ram_we;
   logic [6:0]        ram_raddr;
   logic              ram_rd;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
`ifdef ZIGZAG_BUF_DBG_CNT_EN
   logic [15:0]       dbg_blk_in;
   logic [15:0]       dbg_blk_out;
   logic              dbg_stall_err;
`endif

   always #5 clk = ~clk;

   zigzag_buf_ctrl #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ram_d     (ram_d),
      .ram_waddr (ram_waddr),
      .ram_we    (ram_we),
      .ram_raddr (ram_raddr),
      .ram_rd    (ram_rd),
      .ram_q     (ram_q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
`ifdef ZIGZAG_BUF_DBG_CNT_EN
      , .dbg_blk_in    (dbg_blk_in)
      , .dbg_blk_out   (dbg_blk_out)
      , .dbg_stall_err (dbg_stall_err)
`endif
   );

   // RAMZ model: synchronous write, registered read address
   logic [DATA_W-1:0] ram_mem [128];
   logic [6:0]        ram_raddr_q = 7'd0;
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_waddr] <= ram_d;
      if (ram_rd) ram_raddr_q <= ram_raddr;
   end
   assign ram_q = ram_mem[ram_raddr_q];

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
      end
   endtask

   // Reference zigzag order: walk the 15 anti-diagonals, alternating direction
   int zz [64];
   function automatic void build_zz();
      int n = 0;
      for (int s = 0; s < 15; s++) begin
         int lo;
         int hi;
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
         end
      end
   endfunction

   // Scoreboard state
   logic [DATA_W-1:0] blk_buf [64];
   int                blk_cnt   = 0;
   logic              wr_bank_m = 1'b0;
   logic [DATA_W-1:0] exp_d [$];
   logic              exp_l [$];
   int                n_out = 0;
   int                n_last = 0;
   int                n_acc = 0;
   int                cyc = 0;
   int                first_out_cyc = -1;
   int                last_out_cyc = 0;
   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_d;
   logic              prev_l;

   // Monitor: sample handshakes mid-cycle, before the edge that commits them
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         blk_cnt    = 0;
         wr_bank_m  = 1'b0;
         prev_stall = 1'b0;
         exp_d.delete();
         exp_l.delete();
      end else begin
         if (prev_stall) begin
            check_val("hold_valid", out_valid, 1'b1);
            check_val("hold_data", out_data, prev_d);
            check_val("hold_last", out_last, prev_l);
         end
         if (out_valid && out_ready) begin
            if (exp_d.size() == 0) begin
               check_val("out_unexpected", out_valid, 1'b0);
            end else begin
               check_val("out_data", out_data, exp_d.pop_front());
               check_val("out_last", out_last, exp_l.pop_front());
            end
            n_out++;
            if (out_last) n_last++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_l     = out_last;

         check_val("ram_we", ram_we, in_valid && in_ready);
         if (in_valid && in_ready) begin
            check_val("ram_waddr", ram_waddr, {wr_bank_m, blk_cnt[5:0]});
            check_val("ram_d", ram_d, in_data);
            blk_buf[blk_cnt] = in_data;
            blk_cnt++;
            n_acc++;
            if (blk_cnt == 64) begin
               for (int k = 0; k < 64; k++) begin
                  exp_d.push_back(blk_buf[zz[k]]);
                  exp_l.push_back(k == 63);
               end
               blk_cnt   = 0;
               wr_bank_m = ~wr_bank_m;
            end
         end
      end
   end

   logic rnd_ready = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      int t = 0;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < LIM) begin
         step();
         @(negedge clk);
         t++;
      end
      check_val("in_accept_wait", t < LIM, 1'b1);
      step();
   endtask

   task automatic drain();
      int t = 0;
      in_valid = 1'b0;
      while ((exp_d.size() != 0 || out_valid) && t < LIM) begin
         step();
         t++;
      end
      check_val("drain_left", exp_d.size(), 0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   int n0;
   int a0;

   initial begin
      build_zz();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = '1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_in_ready", in_ready, 1'b1);
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_out_last", out_last, 1'b0);
      check_val("rst_ram_we", ram_we, 1'b0);
      check_val("rst_ram_rd", ram_rd, 1'b0);
      check_val("rst_ram_waddr", ram_waddr, 7'd0);
      check_val("rst_ram_raddr", ram_raddr, 7'd0);
      check_val("rst_ram_d", ram_d, 12'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      step();

      // Single block, data = k
      n0 = n_out;
      a0 = n_last;
      for (int k = 0; k < 64; k++) push(DATA_W'(k));
      drain();
      check_val("single_count", n_out - n0, 64);
      check_val("single_lasts", n_last - a0, 1);

      // Four back-to-back blocks, in_valid held high
      n0 = n_out;
      first_out_cyc = -1;
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 64; k++) push(DATA_W'(64 * b + k));
      drain();
      check_val("b2b_count", n_out - n0, 256);
      check_val("b2b_span_ok", (last_out_cyc - first_out_cyc) <= 262, 1'b1);

      // Output stalled for 200 cycles while three blocks are offered
      n0 = n_out;
      a0 = n_acc;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 192; i++) push(DATA_W'($urandom));
            in_valid = 1'b0;
         end
         begin
            repeat (200) @(posedge clk);
            @(negedge clk);
            check_val("stall_accepts", n_acc - a0, 128);
            check_val("stall_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check_val("stall_count", n_out - n0, 192);

      // Random output backpressure and input gaps
      n0 = n_out;
      rnd_ready = 1'b1;
      for (int i = 0; i < 6 * 64; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
         end
         push(DATA_W'($urandom));
      end
      drain();
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      check_val("rand_count", n_out - n0, 384);

      // Reset at coefficient 30 of block 2
      for (int i = 0; i < 2 * 64 + 30; i++) push(DATA_W'(i));
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check_val("mid_rst_in_ready", in_ready, 1'b1);
      check_val("mid_rst_out_valid", out_valid, 1'b0);
      step();
      n0 = n_out;
      for (int k = 0; k < 64; k++) push(DATA_W'(3000 + k));
      drain();
      check_val("post_rst_count", n_out - n0, 64);

`ifdef ZIGZAG_BUF_DBG_CNT_EN
      do_reset();
      for (int i = 0; i < 5 * 64; i++) push(DATA_W'($urandom));
      drain();
      repeat (4) step();
      check_val("dbg_blk_in_5", dbg_blk_in, 16'd5);
      check_val("dbg_blk_out_5", dbg_blk_out, 16'd5);
      check_val("dbg_err_clear", dbg_stall_err, 1'b0);
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 192; i++) push(DATA_W'($urandom));
            in_valid = 1'b0;
         end
         begin
            repeat (440) @(posedge clk);
            @(negedge clk);
            check_val("dbg_blk_in_7", dbg_blk_in, 16'd7);
            check_val("dbg_blk_out_stall", dbg_blk_out, 16'd5);
            check_val("dbg_stall_err", dbg_stall_err, 1'b1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
`else
      do_reset();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
      $fatal(1, "timeout");
   end

endmodule : tb_zigzag_buf_ctrl
